hindbrain_reflex_monitor: RTL

Parametrised N-channel sensor reflex monitor with an AXI-Lite register slave. It is the successor to the hindbrain's fixed three-sensor, hard-coded-threshold alarm logic. Each channel has host-programmable high/low thresholds with hysteresis, a debounced alarm FSM, an optional peak-hold register, and a reflex output that acts without host involvement. Alarm entries are collected in a W1C interrupt-status register gated by a mask, and drive one interrupt to the host via XDMA.

---
 rtl/hindbrain_pkg.sv | 48 ++++
 rtl/hindbrain_alarm_channel.sv | 131 +++++++++++++
 rtl/hindbrain_reflex_monitor.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hindbrain_pkg.sv
// Shared definitions for the hindbrain reflex monitor: register map,
// ID values, channel state encoding and AXI-Lite write-strobe helpers.
package hindbrain_pkg;

    // Global register byte offsets
    localparam logic [11:0] ADDR_ID          = 12'h000;
    localparam logic [11:0] ADDR_IRQ_STATUS  = 12'h004;
    localparam logic [11:0] ADDR_IRQ_MASK    = 12'h008;
    localparam logic [11:0] ADDR_ALARM_STATE = 12'h00C;
    localparam logic [11:0] ADDR_DEBOUNCE    = 12'h010;

    // Channel window: 0x100 + c*0x10, selected by address bits [11:8]
    localparam logic [3:0] CH_REGION     = 4'h1;
    localparam logic [3:0] CH_OFF_SAMPLE = 4'h0;
    localparam logic [3:0] CH_OFF_HI     = 4'h4;
    localparam logic [3:0] CH_OFF_LO     = 4'h8;
    localparam logic [3:0] CH_OFF_PEAK   = 4'hC;

    // ID register contents with and without the peak-hold feature
    localparam logic [31:0] ID_PEAK_HOLD    = 32'h4842_0100;
    localparam logic [31:0] ID_NO_PEAK_HOLD = 32'h4842_0000;

    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;
    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        PENDING = 2'd1,
        ALARM   = 2'd2
    } ch_state_e;

    // Expand the four byte strobes into a 32-bit bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    // Replace only the strobed bytes of a register value
    function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/hindbrain_alarm_channel.sv
// One sensor channel: debounced NORMAL/PENDING/ALARM FSM, last-sample
// register and, when HINDBRAIN_PEAK_HOLD_EN is defined, a peak-hold register.
module hindbrain_alarm_channel
    import hindbrain_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEBOUNCE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     sample_data,
    input  logic                  sample_valid,
    input  logic [DATA_W-1:0]     hi_thresh,
    input  logic [DATA_W-1:0]     lo_thresh,
    input  logic [DEBOUNCE_W-1:0] debounce,
    input  logic                  peak_clr,
    output logic [DATA_W-1:0]     last_sample,
    output logic [DATA_W-1:0]     peak,
    output logic                  alarm,
    output logic                  alarm_entry
);

    localparam logic [DEBOUNCE_W-1:0] CNT_ONE = DEBOUNCE_W'(1);

    ch_state_e             state_q, state_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0]     sample_q, sample_d;
    logic                  alarm_q, alarm_d;

    // Next-state logic: thresholds are only evaluated on a valid sample
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        alarm_entry = 1'b0;

        if (sample_valid) begin
            sample_d = sample_data;
            case (state_q)
                NORMAL: begin
                    if (sample_data > hi_thresh) begin
                        if (debounce <= CNT_ONE) begin
                            state_d = ALARM;
                            cnt_d   = '0;
                        end else begin
                            state_d = PENDING;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                PENDING: begin
                    if (sample_data > hi_thresh) begin
                        // >= so a DEBOUNCE lowered mid-count still completes
                        if (cnt_inc >= debounce) begin
                            state_d = ALARM;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = NORMAL;
                        cnt_d   = '0;
                    end
                end
                ALARM: begin
                    if (sample_data < lo_thresh) begin
                        state_d = NORMAL;
                    end
                end
                default: begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            endcase
            alarm_entry = (state_q != ALARM) && (state_d == ALARM);
        end

        alarm_d = (state_d == ALARM);
    end

    // State, debounce count, last sample and registered alarm output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= NORMAL;
            cnt_q    <= '0;
            sample_q <= '0;
            alarm_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            alarm_q  <= alarm_d;
        end
    end

    assign last_sample = sample_q;
    assign alarm       = alarm_q;

`ifdef HINDBRAIN_PEAK_HOLD_EN
    logic [DATA_W-1:0] peak_q, peak_d;

    // Running maximum of valid samples; a host write clears it
    always_comb begin
        peak_d = peak_q;
        if (peak_clr) begin
            peak_d = '0;
        end else if (sample_valid && (sample_data > peak_q)) begin
            peak_d = sample_data;
        end
    end

    // Peak register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`else
    logic peak_clr_unused;
    assign peak_clr_unused = peak_clr;
    assign peak            = '0;
`endif

endmodule

// File: rtl/hindbrain_reflex_monitor.sv
// N-channel sensor reflex monitor with AXI-Lite register slave.
// Holds the AXI-Lite slave, global registers, thresholds and irq reduction.
// HINDBRAIN_PEAK_HOLD_EN selects the per-channel peak-hold registers and ID.
module hindbrain_reflex_monitor
    import hindbrain_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 16,
    parameter int DEBOUNCE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] sensor_data,
    input  logic [NUM_CH-1:0]        sensor_valid,
    input  logic [11:0]              s_axil_awaddr,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [31:0]              s_axil_wdata,
    input  logic [3:0]               s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    input  logic [11:0]              s_axil_araddr,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,
    output logic [NUM_CH-1:0]        reflex_alarm,
    output logic                     irq
);

`ifdef HINDBRAIN_PEAK_HOLD_EN
    localparam logic [31:0] ID_VALUE = ID_PEAK_HOLD;
`else
    localparam logic [31:0] ID_VALUE = ID_NO_PEAK_HOLD;
`endif

    // AXI-Lite handshake state
    logic        rdy_en_q, rdy_en_d;
    logic        aw_q, aw_d;
    logic [11:0] awaddr_q, awaddr_d;
    logic        w_q, w_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    // Global and per-channel configuration
    logic [NUM_CH-1:0]     irq_status_q, irq_status_d;
    logic [NUM_CH-1:0]     irq_mask_q, irq_mask_d;
    logic [DEBOUNCE_W-1:0] debounce_q, debounce_d;
    logic [DATA_W-1:0]     hi_q [NUM_CH];
    logic [DATA_W-1:0]     hi_d [NUM_CH];
    logic [DATA_W-1:0]     lo_q [NUM_CH];
    logic [DATA_W-1:0]     lo_d [NUM_CH];
    logic                  irq_q, irq_d;

    // Channel results
    logic [DATA_W-1:0] ch_sample [NUM_CH];
    logic [DATA_W-1:0] ch_peak   [NUM_CH];
    logic [NUM_CH-1:0] ch_alarm, ch_entry, peak_clr;

    // Write-path intermediates
    logic        aw_hs, w_hs, wr_fire;
    logic [11:0] wr_addr, wr_word;
    logic [31:0] wr_data, wr_mask;
    logic [NUM_CH-1:0] w1c_clr;

    // Read-path intermediates
    logic        ar_hs;
    logic [11:0] rd_word;
    logic [31:0] rd_val;

    logic addr_lsb_unused;
    assign addr_lsb_unused = ^{wr_addr[1:0], s_axil_araddr[1:0]};

    assign s_axil_awready = rdy_en_q & ~aw_q & ~bvalid_q;
    assign s_axil_wready  = rdy_en_q & ~w_q & ~bvalid_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = AXI_RESP_OKAY;
    assign s_axil_arready = rdy_en_q & ~rvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = AXI_RESP_OKAY;
    assign reflex_alarm   = ch_alarm;
    assign irq            = irq_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        hindbrain_alarm_channel #(
            .DATA_W     (DATA_W),
            .DEBOUNCE_W (DEBOUNCE_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .sample_data  (sensor_data[c*DATA_W +: DATA_W]),
            .sample_valid (sensor_valid[c]),
            .hi_thresh    (hi_q[c]),
            .lo_thresh    (lo_q[c]),
            .debounce     (debounce_q),
            .peak_clr     (peak_clr[c]),
            .last_sample  (ch_sample[c]),
            .peak         (ch_peak[c]),
            .alarm        (ch_alarm[c]),
            .alarm_entry  (ch_entry[c])
        );
    end

    // Write channel: capture AW and W independently, commit when both are held
    always_comb begin
        rdy_en_d = 1'b1;
        aw_hs    = s_axil_awvalid & s_axil_awready;
        w_hs     = s_axil_wvalid & s_axil_wready;
        wr_fire  = (aw_q | aw_hs) & (w_q | w_hs);
        wr_addr  = aw_q ? awaddr_q : s_axil_awaddr;
        wr_word  = {wr_addr[11:2], 2'b00};
        wr_data  = w_q ? wdata_q : s_axil_wdata;
        wr_mask  = strb_mask(w_q ? wstrb_q : s_axil_wstrb);

        aw_d     = aw_q;
        awaddr_d = awaddr_q;
        w_d      = w_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;

        if (wr_fire) begin
            aw_d     = 1'b0;
            w_d      = 1'b0;
            bvalid_d = 1'b1;
        end else begin
            if (aw_hs) begin
                aw_d     = 1'b1;
                awaddr_d = s_axil_awaddr;
            end
            if (w_hs) begin
                w_d     = 1'b1;
                wdata_d = s_axil_wdata;
                wstrb_d = s_axil_wstrb;
            end
        end
        if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        irq_mask_d = irq_mask_q;
        debounce_d = debounce_q;
        w1c_clr    = '0;
        peak_clr   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hi_d[c] = hi_q[c];
            lo_d[c] = lo_q[c];
        end

        if (wr_fire) begin
            if (wr_word == ADDR_IRQ_STATUS) begin
                w1c_clr = NUM_CH'(wr_data & wr_mask);
            end else if (wr_word == ADDR_IRQ_MASK) begin
                irq_mask_d = NUM_CH'(merge_write(32'(irq_mask_q), wr_data, wr_mask));
            end else if (wr_word == ADDR_DEBOUNCE) begin
                debounce_d = DEBOUNCE_W'(merge_write(32'(debounce_q), wr_data, wr_mask));
            end else if (wr_word[11:8] == CH_REGION) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (wr_word[7:4] == 4'(c)) begin
                        case (wr_word[3:0])
                            CH_OFF_HI:   hi_d[c] = DATA_W'(merge_write(32'(hi_q[c]), wr_data, wr_mask));
                            CH_OFF_LO:   lo_d[c] = DATA_W'(merge_write(32'(lo_q[c]), wr_data, wr_mask));
                            CH_OFF_PEAK: peak_clr[c] = 1'b1;
                            default:     ;
                        endcase
                    end
                end
            end
        end

        // A new alarm entry outranks a W1C landing in the same cycle
        irq_status_d = (irq_status_q & ~w1c_clr) | ch_entry;
        irq_d        = |(irq_status_q & irq_mask_q);
    end

    // Read channel: decode at AR acceptance, hold RDATA until RREADY
    always_comb begin
        rd_word = {s_axil_araddr[11:2], 2'b00};
        rd_val  = UNMAPPED_DATA;
        if (rd_word == ADDR_ID) begin
            rd_val = ID_VALUE;
        end else if (rd_word == ADDR_IRQ_STATUS) begin
            rd_val = 32'(irq_status_q);
        end else if (rd_word == ADDR_IRQ_MASK) begin
            rd_val = 32'(irq_mask_q);
        end else if (rd_word == ADDR_ALARM_STATE) begin
            rd_val = 32'(ch_alarm);
        end else if (rd_word == ADDR_DEBOUNCE) begin
            rd_val = 32'(debounce_q);
        end else if (rd_word[11:8] == CH_REGION) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (rd_word[7:4] == 4'(c)) begin
                    case (rd_word[3:0])
                        CH_OFF_SAMPLE: rd_val = 32'(ch_sample[c]);
                        CH_OFF_HI:     rd_val = 32'(hi_q[c]);
                        CH_OFF_LO:     rd_val = 32'(lo_q[c]);
                        CH_OFF_PEAK:   rd_val = 32'(ch_peak[c]);
                        default:       ;
                    endcase
                end
            end
        end

        ar_hs    = s_axil_arvalid & s_axil_arready;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
        end
    end

    // All top-level state; reset drops every ready and pending response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en_q     <= 1'b0;
            aw_q         <= 1'b0;
            awaddr_q     <= '0;
            w_q          <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bvalid_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            irq_status_q <= '0;
            irq_mask_q   <= '0;
            debounce_q   <= DEBOUNCE_W'(4);
            irq_q        <= 1'b0;
            // NOTE: threshold arrays are host-visible config, so each entry gets a defined reset value like any flop.
            for (int c = 0; c < NUM_CH; c++) begin
                hi_q[c] <= '1;
                lo_q[c] <= '0;
            end
        end else begin
            rdy_en_q     <= rdy_en_d;
            aw_q         <= aw_d;
            awaddr_q     <= awaddr_d;
            w_q          <= w_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bvalid_q     <= bvalid_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            irq_status_q <= irq_status_d;
            irq_mask_q   <= irq_mask_d;
            debounce_q   <= debounce_d;
            irq_q        <= irq_d;
            for (int c = 0; c < NUM_CH; c++) begin
                hi_q[c] <= hi_d[c];
                lo_q[c] <= lo_d[c];
            end
        end
    end

endmodule
